mem_access_unit: RTL and testbench

//   MEM-stage load/store controller sitting directly upstream of the word-addressed data RAM.

---
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus the word-RAM port of the MEM-stage load/store unit.
// The slave modport is the unit; the master modport is the pipeline/RAM side.
interface mem_access_unit_if;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_write;
    logic          ram_write_en;
    logic          ram_read_en;
    logic [DW-1:0] ram_data_out;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, ram_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_address, ram_data_write, ram_write_en, ram_read_en
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, ram_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_address, ram_data_write, ram_write_en, ram_read_en
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: maps byte/half/word accesses onto a 32-bit word RAM,
// using read-modify-write for sub-word stores and sign/zero extension for loads.
module mem_access_unit #(
    parameter int unsigned RAM_WORDS  = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t          state, state_d;

    logic            cap_write, cap_signed;
    logic [1:0]      cap_size, cap_lane;
    logic [DW-1:0]   cap_wdata;

    logic            req_ready_q, resp_valid_q, resp_err_q, ram_write_en_q, ram_read_en_q;
    logic [DW-1:0]   resp_rdata_q, ram_data_write_q;
    logic [31:0]     ram_address_q;

    logic            req_ready_d, resp_valid_d, resp_err_d, ram_write_en_d, ram_read_en_d;
    logic [DW-1:0]   resp_rdata_d, ram_data_write_d;
    logic [31:0]     ram_address_d;

    logic            accept_c, req_err_c, needs_read_c;
    logic [4:0]      lane_shift_c;
    logic [7:0]      rd_byte_c;
    logic [15:0]     rd_half_c;
    logic [DW-1:0]   rd_word_c, lane_mask_c, load_data_c, merge_data_c;

    assign accept_c = (state == IDLE) && bus.req_valid;

    // Misalignment, illegal size and out-of-range word index are all reported without a RAM access
    always_comb begin
        req_err_c = 1'b0;
        case (bus.req_size)
            2'b00:   req_err_c = 1'b0;
            2'b01:   req_err_c = bus.req_addr[0];
            2'b10:   req_err_c = |bus.req_addr[1:0];
            default: req_err_c = 1'b1;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= RAM_LIMIT) begin
            req_err_c = 1'b1;
        end
        needs_read_c = !bus.req_write || (bus.req_size != 2'b10);
    end

    // Lane extraction for loads and lane merge for sub-word stores, little-endian
    always_comb begin
        rd_word_c    = bus.ram_data_out;
        lane_shift_c = {cap_lane, 3'b000};
        rd_byte_c    = 8'(rd_word_c >> lane_shift_c);
        rd_half_c    = cap_lane[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        case (cap_size)
            2'b00:   load_data_c = {{24{cap_signed & rd_byte_c[7]}}, rd_byte_c};
            2'b01:   load_data_c = {{16{cap_signed & rd_half_c[15]}}, rd_half_c};
            default: load_data_c = rd_word_c;
        endcase
        lane_mask_c  = (cap_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        merge_data_c = (rd_word_c & ~(lane_mask_c << lane_shift_c))
                     | ((cap_wdata & lane_mask_c) << lane_shift_c);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cap_write        <= 1'b0;
            cap_signed       <= 1'b0;
            cap_size         <= 2'b00;
            cap_lane         <= 2'b00;
            cap_wdata        <= '0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
            ram_write_en_q   <= 1'b0;
            ram_read_en_q    <= 1'b0;
            ram_address_q    <= '0;
            ram_data_write_q <= '0;
        end else begin
            state            <= state_d;
            if (accept_c) begin
                cap_write  <= bus.req_write;
                cap_signed <= bus.req_signed;
                cap_size   <= bus.req_size;
                cap_lane   <= bus.req_addr[1:0];
                cap_wdata  <= bus.req_wdata;
            end
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
            ram_write_en_q   <= ram_write_en_d;
            ram_read_en_q    <= ram_read_en_d;
            ram_address_q    <= ram_address_d;
            ram_data_write_q <= ram_data_write_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    if (req_err_c)         state_d = RESP;
                    else if (needs_read_c) state_d = READ;
                    else                   state_d = WRITE;
                end
            end
            READ:  state_d = cap_write ? WRITE : RESP;
            WRITE: state_d = RESP;
            RESP:  if (bus.resp_ready) state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; strobes default low so each lasts one cycle
    always_comb begin
        req_ready_d      = (state_d == IDLE);
        resp_valid_d     = (state_d == RESP);
        resp_err_d       = resp_err_q;
        resp_rdata_d     = resp_rdata_q;
        ram_write_en_d   = 1'b0;
        ram_read_en_d    = 1'b0;
        ram_address_d    = ram_address_q;
        ram_data_write_d = ram_data_write_q;
        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    resp_err_d   = req_err_c;
                    resp_rdata_d = '0;
                    if (!req_err_c) begin
                        ram_address_d = {bus.req_addr[31:2], 2'b00};
                        if (needs_read_c) begin
                            ram_read_en_d = 1'b1;
                        end else begin
                            ram_write_en_d   = 1'b1;
                            ram_data_write_d = bus.req_wdata;
                        end
                    end
                end
            end
            READ: begin
                if (cap_write) begin
                    ram_write_en_d   = 1'b1;
                    ram_data_write_d = merge_data_c;
                end else begin
                    resp_rdata_d = load_data_c;
                end
            end
            WRITE: resp_rdata_d = '0;
            RESP:  ;
        endcase
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.ram_write_en   = ram_write_en_q;
    assign bus.ram_read_en    = ram_read_en_q;
    assign bus.ram_address    = ram_address_q;
    assign bus.ram_data_write = ram_data_write_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word behavioural data RAM.
module tb_mem_access_unit;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;
    int   rd_cnt;
    int   wr_cnt;
    logic [31:0] last_rd_addr;
    logic [31:0] ram [32];

    mem_access_unit_if bus ();

    mem_access_unit #(.RAM_WORDS(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ram_data_out = ram[bus.ram_address[6:2]];

    always @(posedge clk) begin
        if (bus.ram_write_en) ram[bus.ram_address[6:2]] <= bus.ram_data_write;
    end

    always @(negedge clk) begin
        if (bus.ram_read_en) begin
            rd_cnt++;
            last_rd_addr = bus.ram_address;
        end
        if (bus.ram_write_en) wr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request; lat = cycles after the accepting edge until resp_valid is seen
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output int lat);
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int rd0;
        int wr0;
        passed = 0; total = 0; rd_cnt = 0; wr_cnt = 0; last_rd_addr = '0;
        for (int i = 0; i < 32; i++) ram[i] = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_strobes", {30'd0, bus.ram_read_en, bus.ram_write_en}, 32'd0);
        check("rst_ram_addr", bus.ram_address, 32'd0);
        check("rst_ram_wdata", bus.ram_data_write, 32'd0);

        // lw from word 2
        ram[2] = 32'h1234_5678;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rdata", bus.resp_rdata, 32'h1234_5678);
        check("lw_err", {31'd0, bus.resp_err}, 32'd0);
        check("lw_rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        check("lw_wr_strobes", 32'(wr_cnt - wr0), 32'd0);
        check("lw_addr", last_rd_addr, 32'h8);
        consume("lw");

        // byte/half loads with sign and zero extension
        ram[1] = 32'h80FF_0011;
        do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, lat);
        check("lb_rdata", bus.resp_rdata, 32'hFFFF_FF80);
        consume("lb");
        do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, lat);
        check("lbu_rdata", bus.resp_rdata, 32'h0000_0080);
        consume("lbu");
        do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, lat);
        check("lh_rdata", bus.resp_rdata, 32'hFFFF_80FF);
        consume("lh");
        do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, lat);
        check("lhu_rdata", bus.resp_rdata, 32'h0000_0011);
        consume("lhu");

        // sb read-modify-write
        ram[1] = 32'h1122_3344;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFF_FFAB, lat);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_rdata", bus.resp_rdata, 32'd0);
        check("sb_err", {31'd0, bus.resp_err}, 32'd0);
        check("sb_ram", ram[1], 32'h1122_AB44);
        check("sb_rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        check("sb_wr_strobes", 32'(wr_cnt - wr0), 32'd1);
        consume("sb");

        // sh into upper half of the same word
        do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, lat);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_ram", ram[1], 32'hBEEF_AB44);
        consume("sh");

        // sw goes straight to WRITE
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFE_F00D, lat);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_ram", ram[3], 32'hCAFE_F00D);
        check("sw_rd_strobes", 32'(rd_cnt - rd0), 32'd0);
        check("sw_wr_strobes", 32'(wr_cnt - wr0), 32'd1);
        consume("sw");

        // misaligned sh
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 2'b01, 1'b0, 32'h3, 32'h1234, lat);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", {31'd0, bus.resp_err}, 32'd1);
        check("mis_rdata", bus.resp_rdata, 32'd0);
        check("mis_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        consume("mis");

        // illegal size
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat);
        check("size11_err", {31'd0, bus.resp_err}, 32'd1);
        consume("size11");

        // last valid word, then first out-of-range word with held response
        ram[31] = 32'hA5A5_0F0F;
        do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, lat);
        check("lw_top_err", {31'd0, bus.resp_err}, 32'd0);
        check("lw_top_rdata", bus.resp_rdata, 32'hA5A5_0F0F);
        consume("lw_top");
        rd0 = rd_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat);
        check("oor_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("oor_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("oor_hold_err", {31'd0, bus.resp_err}, 32'd1);
            check("oor_hold_rdata", bus.resp_rdata, 32'd0);
            check("oor_hold_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        check("oor_no_read", 32'(rd_cnt - rd0), 32'd0);
        consume("oor");

        // reset during the WRITE cycle of a sub-word store
        ram[0] = 32'hFFFF_FFFF;
        bus.req_write = 1'b1; bus.req_size = 2'b01; bus.req_signed = 1'b0;
        bus.req_addr = 32'h2; bus.req_wdata = 32'h0000_1234; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rstw_read_cycle", {31'd0, bus.ram_read_en}, 32'd1);
        @(posedge clk); #1;
        check("rstw_write_cycle", {31'd0, bus.ram_write_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_we_drop", {31'd0, bus.ram_write_en}, 32'd0);
        check("rstw_resp_none", {31'd0, bus.resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstw_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rstw_resp_after", {31'd0, bus.resp_valid}, 32'd0);

        // unit is usable again
        do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, lat);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_rdata", bus.resp_rdata, 32'hCAFE_F00D);
        consume("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
